// File: rtl/toeplitz_row_accumulator.sv
// GF(2) Toeplitz matrix-vector product for privacy amplification.
// Each shifted seed row is XORed into an accumulator when the matching
// raw-key bit (taken MSB first from KEY_W-bit words) is 1. After N_ROWS
// rows the accumulator is presented as the hash until acknowledged.
//
// Handshakes: a transfer on a valid/ready pair happens on a rising clk_in
// edge where both valid and ready are high. key_ready and row_ready are
// decoded from registered state only, never from valid; valid may be raised
// at any time and is ignored when the matching ready is low. The one
// exception is underrun: row_valid while no key bit is held in RUN is
// recorded (sticky) and the row is dropped.
module toeplitz_row_accumulator #(
  parameter int OUT_W  = 3072,
  parameter int N_ROWS = 4096,
  parameter int KEY_W  = 32,
  localparam int BL_W  = $clog2(KEY_W + 1),
  localparam int RC_W  = $clog2(N_ROWS) + 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic [OUT_W-1:0]  row_in,
  input  logic              row_valid,
  output logic              row_ready,
  input  logic [KEY_W-1:0]  key_word,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [OUT_W-1:0]  hash_out,
  output logic              hash_valid,
  input  logic              hash_ack,
  output logic              busy,
  output logic              underrun,
  output logic [1:0]        dbg_state,
  output logic [RC_W-1:0]   dbg_row_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [OUT_W-1:0]   r_acc;
  logic [OUT_W-1:0]   r_hash_out;
  logic [KEY_W-1:0]   r_shreg;
  logic [BL_W-1:0]    r_bits_left;
  logic [RC_W-1:0]    r_row_cnt;
  logic               r_underrun;

  logic               w_in_run;
  logic               w_key_ready;
  logic               w_row_ready;
  logic               w_key_fire;
  logic               w_row_fire;
  logic               w_underrun_hit;
  logic               w_last_row;
  logic [OUT_W-1:0]   w_acc_next;

  assign w_in_run       = (r_state == S_RUN);
  assign w_key_ready    = w_in_run && (r_bits_left == '0);
  assign w_row_ready    = w_in_run && (r_bits_left != '0);
  assign w_key_fire     = w_key_ready && key_valid;
  assign w_row_fire     = w_row_ready && row_valid;
  // A row offered while the key register is empty is lost and flagged.
  assign w_underrun_hit = w_in_run && row_valid && (r_bits_left == '0);
  assign w_last_row     = (r_row_cnt == RC_W'(N_ROWS - 1));
  // The current key bit selects whether this row contributes to the product.
  assign w_acc_next     = r_shreg[KEY_W-1] ? (r_acc ^ row_in) : r_acc;

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_row_fire && w_last_row) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (hash_ack) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Key shift register: whole-word load when empty, one bit per consumed row.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_bits_left <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_bits_left <= '0;
      end
    end else if (w_in_run) begin
      if (w_key_fire) begin
        r_shreg     <= key_word;
        r_bits_left <= BL_W'(KEY_W);
      end else if (w_row_fire) begin
        r_shreg     <= r_shreg << 1;
        r_bits_left <= r_bits_left - BL_W'(1);
      end
    end
  end

  // Row counter: counts consumed rows only; dropped rows do not advance it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_row_cnt <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_row_cnt <= '0;
    end else if (w_row_fire) begin
      r_row_cnt <= r_row_cnt + RC_W'(1);
    end
  end

  // Accumulator: zero outside a block, cleared again on acknowledge.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else begin
      case (r_state)
        S_IDLE:  r_acc <= '0;
        S_RUN:   if (w_row_fire) r_acc <= w_acc_next;
        S_DONE:  if (hash_ack) r_acc <= '0;
        default: r_acc <= '0;
      endcase
    end
  end

  // Result register: captures the final accumulator (including the last row)
  // on entry to DONE and keeps it until the next block completes.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_hash_out <= '0;
    end else if (w_row_fire && w_last_row) begin
      r_hash_out <= w_acc_next;
    end
  end

  // Sticky underrun flag, cleared only by a new start.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_hit) begin
      r_underrun <= 1'b1;
    end
  end

  assign row_ready   = w_row_ready;
  assign key_ready   = w_key_ready;
  assign hash_out    = r_hash_out;
  assign hash_valid  = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign underrun    = r_underrun;
  assign dbg_state   = r_state;
  assign dbg_row_cnt = r_row_cnt;

endmodule

// File: tb/tb_toeplitz_row_accumulator.sv
// Bench for toeplitz_row_accumulator: a small instance (8-bit rows, 64 rows)
// for directed and random blocks, plus a default-size instance for a full
// random block. Expected hashes come from a bit-level model of the product.
module tb_toeplitz_row_accumulator;

  localparam int S_OUT  = 8;
  localparam int S_ROWS = 64;
  localparam int B_OUT  = 3072;
  localparam int B_ROWS = 4096;
  localparam int KW     = 32;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- small instance ----------------
  logic              s_start, s_row_valid, s_row_ready, s_key_valid, s_key_ready;
  logic [S_OUT-1:0]  s_row_in, s_hash_out;
  logic [KW-1:0]     s_key_word;
  logic              s_hash_valid, s_hash_ack, s_busy, s_underrun;
  logic [1:0]        s_dbg_state;
  logic [6:0]        s_dbg_row_cnt;

  toeplitz_row_accumulator #(.OUT_W(S_OUT), .N_ROWS(S_ROWS), .KEY_W(KW)) u_small (
    .clk_in(clk_in), .rst(rst), .start(s_start),
    .row_in(s_row_in), .row_valid(s_row_valid), .row_ready(s_row_ready),
    .key_word(s_key_word), .key_valid(s_key_valid), .key_ready(s_key_ready),
    .hash_out(s_hash_out), .hash_valid(s_hash_valid), .hash_ack(s_hash_ack),
    .busy(s_busy), .underrun(s_underrun),
    .dbg_state(s_dbg_state), .dbg_row_cnt(s_dbg_row_cnt)
  );

  // ---------------- default-size instance ----------------
  logic              b_start, b_row_valid, b_row_ready, b_key_valid, b_key_ready;
  logic [B_OUT-1:0]  b_row_in, b_hash_out;
  logic [KW-1:0]     b_key_word;
  logic              b_hash_valid, b_hash_ack, b_busy, b_underrun;
  logic [1:0]        b_dbg_state;
  logic [12:0]       b_dbg_row_cnt;

  toeplitz_row_accumulator u_big (
    .clk_in(clk_in), .rst(rst), .start(b_start),
    .row_in(b_row_in), .row_valid(b_row_valid), .row_ready(b_row_ready),
    .key_word(b_key_word), .key_valid(b_key_valid), .key_ready(b_key_ready),
    .hash_out(b_hash_out), .hash_valid(b_hash_valid), .hash_ack(b_hash_ack),
    .busy(b_busy), .underrun(b_underrun),
    .dbg_state(b_dbg_state), .dbg_row_cnt(b_dbg_row_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [S_OUT-1:0] s_exp_q[$];
  logic [B_OUT-1:0] b_exp_q[$];
  logic             s_hv_q = 1'b0;
  logic             b_hv_q = 1'b0;
  logic [S_OUT-1:0] s_exp_pop;
  logic [B_OUT-1:0] b_exp_pop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Small-instance monitor: compares each newly presented hash.
  always @(negedge clk_in) begin
    if (s_hash_valid && !s_hv_q) begin
      if (s_exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL small_hash_unexpected: got %0h expected none", s_hash_out);
      end else begin
        s_exp_pop = s_exp_q.pop_front();
        check("small_hash", 64'(s_hash_out), 64'(s_exp_pop));
      end
    end
    s_hv_q <= s_hash_valid;
  end

  // Default-size monitor: full-width compare, low 64 bits printed.
  always @(negedge clk_in) begin
    if (b_hash_valid && !b_hv_q) begin
      n_cmp++;
      if (b_exp_q.size() == 0) begin
        n_err++;
        $display("FAIL big_hash_unexpected: got low64 %0h expected none", b_hash_out[63:0]);
      end else begin
        b_exp_pop = b_exp_q.pop_front();
        if (b_hash_out !== b_exp_pop) begin
          n_err++;
          $display("FAIL big_hash: got low64 %0h expected low64 %0h",
                   b_hash_out[63:0], b_exp_pop[63:0]);
        end
      end
    end
    b_hv_q <= b_hash_valid;
  end

  // ---------------- drivers ----------------
  // mode 0: row i = i, mode 1: row i = i+1, otherwise random rows.
  task automatic run_small(input logic [31:0] k0, input logic [31:0] k1, input int mode,
                           input bit pre_underrun, input bit junk, input int abort_after);
    logic [S_OUT-1:0] rows[S_ROWS];
    logic [31:0]      keys[2];
    logic [S_OUT-1:0] exp;
    int kidx, ridx, gap, burst, cyc;
    bit aborted;
    keys[0] = k0;
    keys[1] = k1;
    exp = '0;
    for (int i = 0; i < S_ROWS; i++) begin
      case (mode)
        0:       rows[i] = 8'(i);
        1:       rows[i] = 8'(i + 1);
        default: rows[i] = 8'($urandom);
      endcase
      if (keys[i / 32][31 - (i % 32)]) exp ^= rows[i];
    end
    if (abort_after < 0) s_exp_q.push_back(exp);

    @(posedge clk_in); #1 s_start = 1'b1;
    @(posedge clk_in); #1 s_start = 1'b0;
    @(negedge clk_in);
    check("small_start_busy_underrun", 64'({s_busy, s_underrun}), 64'b10);
    @(posedge clk_in); #1;

    if (pre_underrun) begin
      s_row_valid = 1'b1;
      s_row_in    = 8'hAA;
      s_key_valid = 1'b0;
      @(posedge clk_in); #1 s_row_valid = 1'b0;
      @(negedge clk_in);
      check("small_underrun_set", 64'(s_underrun), 64'd1);
      check("small_underrun_rowcnt", 64'(s_dbg_row_cnt), 64'd0);
      @(posedge clk_in); #1;
    end

    kidx = 0; ridx = 0; gap = 2; burst = 0; cyc = 0; aborted = 0;
    while (ridx < S_ROWS && cyc < 1000 && !aborted) begin
      s_key_valid = (kidx < 2);
      s_key_word  = keys[kidx & 1];
      s_row_valid = (gap == 0);
      s_row_in    = rows[ridx];
      @(negedge clk_in);
      if (s_key_valid && s_key_ready) kidx++;
      if (s_row_valid && s_row_ready) begin
        ridx++;
        burst++;
        if (burst == 32) begin
          burst = 0;
          gap = 2;
        end
      end else if (gap > 0) begin
        gap--;
      end
      cyc++;
      @(posedge clk_in);
      if (abort_after >= 0 && ridx == abort_after) begin
        #3 rst = 1'b1;
        #1;
        check("small_async_reset",
              64'({s_row_ready, s_key_ready, s_hash_valid, s_busy, s_underrun, s_hash_out, s_dbg_state}),
              64'd0);
        s_row_valid = 1'b0;
        s_key_valid = 1'b0;
        @(negedge clk_in) rst = 1'b0;
        aborted = 1;
      end else begin
        #1;
      end
    end
    s_row_valid = 1'b0;
    s_key_valid = 1'b0;
    if (aborted) return;
    if (ridx < S_ROWS) begin
      n_cmp++;
      n_err++;
      $display("FAIL small_timeout: got %0d rows expected %0d", ridx, S_ROWS);
    end

    @(negedge clk_in);
    check("small_latency_valid", 64'(s_hash_valid), 64'd1);
    check("small_underrun_end", 64'(s_underrun), 64'(pre_underrun));

    repeat (junk ? 10 : 2) begin
      @(posedge clk_in); #1;
      if (junk) begin
        s_start     = 1'($urandom);
        s_row_valid = 1'($urandom);
        s_key_valid = 1'($urandom);
        s_row_in    = 8'($urandom);
      end
      @(negedge clk_in);
      check("small_done_hold",
            64'({s_hash_out, s_dbg_state, s_key_ready, s_row_ready, s_hash_valid}),
            64'({exp, 2'd2, 1'b0, 1'b0, 1'b1}));
    end
    @(posedge clk_in); #1;
    s_start = 1'b0; s_row_valid = 1'b0; s_key_valid = 1'b0; s_hash_ack = 1'b1;
    @(posedge clk_in); #1 s_hash_ack = 1'b0;
    @(negedge clk_in);
    check("small_after_ack",
          64'({s_dbg_state, s_hash_valid, s_busy, s_hash_out}),
          64'({2'd0, 1'b0, 1'b0, exp}));
  endtask

  task automatic run_big();
    logic [31:0]      keys[B_ROWS / KW];
    logic [B_OUT-1:0] row, exp;
    int kidx, ridx, gap, burst, cyc;
    for (int i = 0; i < B_ROWS / KW; i++) keys[i] = $urandom;
    for (int j = 0; j < B_OUT / 32; j++) row[j*32 +: 32] = $urandom;
    exp = '0;

    @(posedge clk_in); #1 b_start = 1'b1;
    @(posedge clk_in); #1 b_start = 1'b0;

    kidx = 0; ridx = 0; gap = 2; burst = 0; cyc = 0;
    while (ridx < B_ROWS && cyc < 10000) begin
      b_key_valid = 1'b1;
      b_key_word  = keys[kidx % (B_ROWS / KW)];
      b_row_valid = (gap == 0);
      b_row_in    = row;
      @(negedge clk_in);
      if (b_key_valid && b_key_ready) kidx++;
      if (b_row_valid && b_row_ready) begin
        if (keys[ridx / 32][31 - (ridx % 32)]) exp ^= row;
        ridx++;
        for (int j = 0; j < B_OUT / 32; j++) row[j*32 +: 32] = $urandom;
        burst++;
        if (burst == 32) begin
          burst = 0;
          gap = 2;
        end
      end else if (gap > 0) begin
        gap--;
      end
      cyc++;
      @(posedge clk_in); #1;
    end
    b_exp_q.push_back(exp);
    b_row_valid = 1'b0;
    b_key_valid = 1'b0;
    if (ridx < B_ROWS) begin
      n_cmp++;
      n_err++;
      $display("FAIL big_timeout: got %0d rows expected %0d", ridx, B_ROWS);
    end
    @(negedge clk_in);
    check("big_latency_valid", 64'(b_hash_valid), 64'd1);
    check("big_underrun", 64'(b_underrun), 64'd0);
    check("big_key_words", 64'(kidx), 64'(B_ROWS / KW));
    @(posedge clk_in); #1 b_hash_ack = 1'b1;
    @(posedge clk_in); #1 b_hash_ack = 1'b0;
    @(negedge clk_in);
    check("big_after_ack", 64'({b_dbg_state, b_hash_valid}), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    s_start = 0; s_row_valid = 0; s_key_valid = 0; s_hash_ack = 0;
    s_row_in = '0; s_key_word = '0;
    b_start = 0; b_row_valid = 0; b_key_valid = 0; b_hash_ack = 0;
    b_row_in = '0; b_key_word = '0;
    repeat (3) @(negedge clk_in);
    check("small_reset",
          64'({s_row_ready, s_key_ready, s_hash_valid, s_busy, s_underrun, s_hash_out, s_dbg_state, s_dbg_row_cnt}),
          64'd0);
    check("big_reset_flags",
          64'({b_row_ready, b_key_ready, b_hash_valid, b_busy, b_underrun, b_dbg_state}), 64'd0);
    check("big_reset_hash_zero", 64'(b_hash_out == '0), 64'd1);
    rst = 1'b0;

    // directed blocks
    run_small(32'h8000_0001, 32'h0000_0000, 0, 1'b0, 1'b0, -1);
    check("t1_hash_value", 64'(s_hash_out), 64'h1F);
    run_small(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, -1);
    check("t2_hash_value", 64'(s_hash_out), 64'h40);
    run_small($urandom, $urandom, 2, 1'b1, 1'b0, -1);
    run_small($urandom, $urandom, 2, 1'b0, 1'b1, -1);
    run_small(32'h8000_0001, 32'h0000_0000, 0, 1'b0, 1'b0, 20);
    run_small(32'h8000_0001, 32'h0000_0000, 0, 1'b0, 1'b0, -1);
    check("t5_hash_value", 64'(s_hash_out), 64'h1F);

    // full-size random block
    run_big();

    // extra random small blocks
    repeat (4) run_small($urandom, $urandom, 2, 1'b0, 1'b0, -1);

    repeat (3) @(negedge clk_in);
    check("small_queue_drained", 64'(s_exp_q.size()), 64'd0);
    check("big_queue_drained", 64'(b_exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
